// File: rtl/matmul_pkg.sv
// Shared FSM state type, index-width helper and default sizes for matmul_seq.
package matmul_pkg;

   localparam int DEF_N   = 32;
   localparam int DEF_B   = 8;
   localparam int DEF_LEN = 4;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, EMIT} state_t;

   // Width of a row/column index; never zero so ports stay legal.
   function automatic int idx_w(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/matmul_seq_dotprod.sv
// DotProd: combinational LEN-term dot product, result wrapped to N bits.
// Each product is built from B-bit slices of the A operand.
module DotProd #(
   parameter int N   = 32,
   parameter int B   = 8,
   parameter int LEN = 4
) (
   input  logic [LEN-1:0][N-1:0] a,
   input  logic [LEN-1:0][N-1:0] b,
   output logic [N-1:0]          y
);

   localparam int NS = (N + B - 1) / B;
   localparam int PW = NS * B;

   logic [PW-1:0] ap;
   logic [N-1:0]  part;
   logic [N-1:0]  acc;

   always_comb begin
      ap   = '0;
      part = '0;
      acc  = '0;
      for (int k = 0; k < LEN; k++) begin
         ap = PW'(a[k]);
         for (int s = 0; s < NS; s++) begin
            part = N'(ap[s*B +: B]) * b[k];
            acc  = acc + (part << (s*B));
         end
      end
   end

   assign y = acc;

endmodule

// File: rtl/matmul_seq.sv
// Sequential LEN x LEN matrix multiply: load A/B element pairs, emit C row-major.
// Define MATMUL_SEQ_B_ROWMAJOR_EN to accept B row-major (stored transposed).
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int B   = DEF_B,
   parameter int LEN = DEF_LEN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [N-1:0]             in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_data,
   output logic [idx_w(LEN)-1:0]    out_row,
   output logic [idx_w(LEN)-1:0]    out_col,
   output logic                     busy
);

   localparam int IW = idx_w(LEN);
   localparam int CW = 2 * IW;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        i, j;
   logic [CW-1:0]        wr_b;
   logic [N-1:0]         mem_a [LEN*LEN];
   logic [N-1:0]         mem_b [LEN*LEN];
   logic [LEN-1:0][N-1:0] row, col;
   logic [N-1:0]         dp;
   logic                 xfer;

   assign in_ready = !reset && (state == IDLE || state == LOAD);
   assign busy     = (state != IDLE);
   assign xfer     = in_valid && in_ready;

   // B is kept column-major internally so column j is a contiguous run.
`ifdef MATMUL_SEQ_B_ROWMAJOR_EN
   assign wr_b = {cnt[IW-1:0], cnt[CW-1:IW]};
`else
   assign wr_b = cnt;
`endif

   // Matrix storage is not reset; a new load always overwrites every entry.
   always_ff @(posedge clk) begin
      if (xfer) begin
         mem_a[cnt]  <= in_a;
         mem_b[wr_b] <= in_b;
      end
   end

   always_comb begin
      row = '0;
      col = '0;
      for (int k = 0; k < LEN; k++) begin
         row[k] = mem_a[{i, IW'(k)}];
         col[k] = mem_b[{j, IW'(k)}];
      end
   end

   DotProd #(.N(N), .B(B), .LEN(LEN)) u_dot (
      .a (row),
      .b (col),
      .y (dp)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         i         <= '0;
         j         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (xfer) begin
                  cnt   <= CW'(1);
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (cnt == CW'(LEN*LEN-1)) begin
                     cnt   <= '0;
                     i     <= '0;
                     j     <= '0;
                     state <= CALC;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            CALC: begin
               out_data  <= dp;
               out_row   <= i;
               out_col   <= j;
               out_valid <= 1'b1;
               state     <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (j == IW'(LEN-1)) begin
                     j <= '0;
                     if (i == IW'(LEN-1)) begin
                        i     <= '0;
                        state <= IDLE;
                     end else begin
                        i     <= i + IW'(1);
                        state <= CALC;
                     end
                  end else begin
                     j     <= j + IW'(1);
                     state <= CALC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq (LEN=4, N=32): loads, stall, wrap, reset abort.
module tb_matmul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_row, out_col;
   logic        busy;

   int ncmp = 0;
   int nfail = 0;

   logic [31:0] ma  [4][4];
   logic [31:0] mb  [4][4];
   logic [31:0] exp_c [16];

   always #5 clk = ~clk;

   matmul_seq #(.N(32), .B(8), .LEN(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Stream all 16 pairs; optional 1010 in_valid pattern. Checks output latency.
   task automatic do_load(input bit gaps);
      int k = 0;
      int t = 0;
      bit hs;
      while (k < 16 && t < 200) begin
         in_valid = gaps ? ((t % 2) == 0) : 1'b1;
         in_a     = ma[k/4][k%4];
`ifdef MATMUL_SEQ_B_ROWMAJOR_EN
         in_b     = mb[k/4][k%4];
`else
         in_b     = mb[k%4][k/4];
`endif
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) k++;
         t++;
      end
      in_valid = 1'b0;
      chk("load_beats", k, 16);
      chk("lat_calc_valid", out_valid, 1'b0);
      chk("lat_calc_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("lat_emit_valid", out_valid, 1'b1);
   endtask

   // Drain results; stall 5 cycles at stall_idx; stop while stop_idx is valid.
   task automatic collect(input int stall_idx, input int stop_idx);
      int idx = 0;
      int t = 0;
      int held = 0;
      bit hs;
      bit was_stall = 0;
      while (idx < 16 && !(idx == stop_idx && out_valid) && t < 400) begin
         if (was_stall) chk("stall_valid", out_valid, 1'b1);
         was_stall = 0;
         if (out_valid) begin
            chk("out_row", out_row, idx / 4);
            chk("out_col", out_col, idx % 4);
            chk("out_data", out_data, exp_c[idx]);
            if (idx == stall_idx && held < 5) begin
               out_ready = 1'b0;
               held++;
               was_stall = 1;
            end else begin
               out_ready = 1'b1;
            end
         end else begin
            out_ready = 1'b1;
         end
         hs = out_valid && out_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         t++;
      end
      out_ready = 1'b0;
      if (stop_idx >= 0) begin
         chk("reach_stop", idx, stop_idx);
      end else begin
         chk("drain_count", idx, 16);
         if (stall_idx >= 0) chk("stall_cycles", held, 5);
         repeat (3) @(posedge clk);
         #1;
         chk("no_extra_valid", out_valid, 1'b0);
         chk("idle_busy", busy, 1'b0);
      end
   endtask

   task automatic ident_set();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = (r == c) ? 32'd1 : 32'd0;
            mb[r][c] = 32'(4*r + c);
            exp_c[4*r + c] = 32'(4*r + c);
         end
   endtask

   task automatic fill_set(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = av;
            mb[r][c] = bv;
            exp_c[4*r + c] = cv;
         end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1'b1);

      // identity x (4r+c), burst load
      ident_set();
      do_load(1'b0);
      collect(-1, -1);

      // all 2 x all 3 -> 4*6 = 24
      fill_set(32'd2, 32'd3, 32'd24);
      do_load(1'b0);
      collect(-1, -1);

      // back-pressure at element (1,2)
      ident_set();
      do_load(1'b0);
      collect(6, -1);

      // 0x8000_0000 * 2 wraps to zero
      fill_set(32'd0, 32'd0, 32'd0);
      ma[0][0] = 32'h8000_0000;
      mb[0][0] = 32'd2;
      do_load(1'b0);
      collect(-1, -1);

      // gapped load gives the same result as the burst
      ident_set();
      do_load(1'b1);
      collect(-1, -1);

      // reset while (2,1) is on the output, then reload all ones -> 4
      do_load(1'b0);
      collect(-1, 9);
      chk("pre_rst_valid", out_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_out_row", out_row, 2'd0);
      chk("arst_out_col", out_col, 2'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("arst_hold_valid", out_valid, 1'b0);
      reset = 1'b0;
      #1;
      fill_set(32'd1, 32'd1, 32'd4);
      do_load(1'b0);
      collect(-1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter N, default 32, element and result width in bits.
REQ-002 SHALL have parameter B, default 8, passed unchanged to the DotProd instance.
REQ-003 SHALL have parameter LEN, default 4, matrix dimension (LEN x LEN), power of two >= 2.
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input element pair valid.
REQ-007 SHALL have port in_ready  output  1  block accepts an element pair.
REQ-008 SHALL have port in_a  input  N  element of A, row-major order.
REQ-009 SHALL have port in_b  input  N  element of B, column-major order (see REQ-027).
REQ-010 SHALL have port out_valid  output  1  out_data holds a C element.
REQ-011 SHALL have port out_ready  input  1  consumer accepts C element.
REQ-012 SHALL have port out_data  output  N  C[out_row][out_col].
REQ-013 SHALL have ports out_row and out_col  output  $clog2(LEN) each  index of out_data.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CALC, EMIT.
REQ-016 SHALL assert in_ready only in IDLE and LOAD; a beat transfers when in_valid && in_ready.
REQ-017 SHALL, on a transfer in IDLE, store the pair at index 0 and go to LOAD; in LOAD, store at the load counter; after beat LEN*LEN-1, go to CALC with i=j=0.
REQ-018 SHALL hold the load counter unchanged in cycles with in_valid low (gaps allowed).
REQ-019 SHALL drive the DotProd inputs combinationally with A row i and B column j.
REQ-020 SHALL, in CALC, register the DotProd result, i and j into out_data/out_row/out_col and go to EMIT.
REQ-021 SHALL hold out_valid high in EMIT, with out_data/out_row/out_col stable, until out_ready.
REQ-022 SHALL, on out_valid && out_ready, advance j, wrapping to 0 with i+1; after (LEN-1, LEN-1), go to IDLE, else to CALC.
REQ-023 SHALL emit C in row-major order at a minimum of 2 cycles per element; first out_valid 2 cycles after the last input beat.
REQ-024 SHALL keep C elements as the N-bit DotProd result, wrapped modulo 2^N, with no saturation and no flag.
REQ-025 SHALL ignore in_valid in CALC and EMIT; in_ready is low there.

Reset
REQ-026 SHALL, on reset asserted at any time, immediately force IDLE, clear all counters, out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, in_ready=0 during reset, and abandon any partial load or emit; matrix storage need not be cleared.

Configuration
REQ-027 SHALL, with macro MATMUL_SEQ_B_ROWMAJOR_EN defined, accept in_b in row-major order and store each beat transposed; without it, accept in_b column-major with no transposition; output order unchanged in both.

Structure
REQ-028 SHALL take the FSM state enum, the index-width function and default parameter constants from shared package matmul_pkg.
REQ-029 SHALL instantiate DotProd #(N,B,LEN) as its single sub-module.

Verification
REQ-030 Bench: A=identity, B[r][c]=4r+c, loaded in one burst -> 16 outputs with C[r][c]=4r+c, row-major, indices matching.
REQ-031 Bench: all A=2, all B=3 -> all 16 out_data=24; first out_valid 2 cycles after the last input beat.
REQ-032 Bench: out_ready low for 5 cycles at element (1,2) -> out_valid, out_data, out_row and out_col stable throughout; no element lost or duplicated.
REQ-033 Bench: A[0][0]=0x8000_0000, B[0][0]=2, all other elements 0 -> C[0][0]=0 (wrap); all other C elements 0.
REQ-034 Bench: reset pulse during EMIT of element (2,1), then a new load of all 1s -> outputs zero during reset, busy=0, next result set all 4.
REQ-035 Bench: in_valid toggled 1010... during load -> results identical to the burst load.
